mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mult_div_unit_divider.sv | 60 ++++++
 rtl/mult_div_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit:
// op encodings, FSM state encoding, divider constants, helpers.
package mdu_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  // Two's-complement negate when n is set.
  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Iterative restoring divider: one quotient bit per step.
// Ports: clk, rst_n, load, step, dividend, divisor, quotient, remainder.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // The quotient register doubles as the dividend shifter:
  // its MSB feeds the partial remainder each step.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs_q};
    // True difference is < 2^WIDTH when ge, so modulo math is exact.
    diff    = shifted[WIDTH-1:0] - dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = ge ? diff : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: 2-edge MULT/MULTU, 34-edge DIV/DIVU.
// Ports: clk, rst_n, start, op, a, b, abort -> busy, done, hi, lo.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             is_mul, is_div;
  logic             is_mthi, is_mtlo;
  logic             op_sgn;
  logic [WIDTH-1:0] dvd_in, dvs_in;
  logic             div_load, div_step;
  logic [WIDTH-1:0] quo, rem;
  logic [63:0]      ma_x, mb_x, prod;

  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);
  assign op_sgn  = (op == OP_MULT) || (op == OP_DIV);

  // Divider works on magnitudes; signs are restored in FIX.
  assign dvd_in = neg_if(op_sgn & a[WIDTH-1], a);
  assign dvs_in = neg_if(op_sgn & b[WIDTH-1], b);

  // Low 64 bits of the extended product are exact for both
  // signed and unsigned operands.
  assign ma_x = sgn_q ? {{32{ma_q[WIDTH-1]}}, ma_q} : {32'd0, ma_q};
  assign mb_x = sgn_q ? {{32{mb_q[WIDTH-1]}}, mb_q} : {32'd0, mb_q};
  assign prod = ma_x * mb_x;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_in),
    .divisor   (dvs_in),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sgn_d    = sgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            unique case (1'b1)
              is_mul: begin
                ma_d    = a;
                mb_d    = b;
                sgn_d   = op_sgn;
                state_d = ST_MUL;
              end
              is_div: begin
                sgn_d    = op_sgn;
                qneg_d   = op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d   = op_sgn & a[WIDTH-1];
                dz_d     = (b == '0);
                div_load = 1'b1;
                cnt_d    = '0;
                state_d  = ST_DIV;
              end
              is_mthi: hi_d = a;
              is_mtlo: lo_d = a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
        ST_DIV: begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_ITERS - 1))
            state_d = ST_FIX;
        end
        ST_FIX: begin
          // Divide by zero: magnitude remainder is |A|, so the
          // dividend-sign fixup already yields Hi=A.
          lo_d    = dz_q ? '1 : neg_if(qneg_q, quo);
          hi_d    = neg_if(rneg_q, rem);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
